// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Control and result bundle for the program-counter sequencer.
//   master modport : the driver of control requests (stall, flush, branch,
//                    jump, call/ret qualifiers) that observes the PC and the
//                    return-address-stack status flags.
//   slave modport  : the sequencer itself.
// Signals:
//   stall                  hold PC and stack
//   flush, flushAddress    redirect (exception / mispredict)
//   branch, branchAddress  taken when branch is 2'b01 or 2'b10
//   jumpReg, jumpAddress   jump request and its target
//   call, ret              qualify jumpReg as push / pop / swap
//   nextPC                 registered program counter
//   rasEmpty, rasFull      registered stack occupancy flags
interface pc_sequencer_if #(
    parameter int PC_WIDTH = 32
);
    logic                stall;
    logic                flush;
    logic [PC_WIDTH-1:0] flushAddress;
    logic [1:0]          branch;
    logic [PC_WIDTH-1:0] branchAddress;
    logic                jumpReg;
    logic [PC_WIDTH-1:0] jumpAddress;
    logic                call;
    logic                ret;
    logic [PC_WIDTH-1:0] nextPC;
    logic                rasEmpty;
    logic                rasFull;

    modport master (
        output stall, flush, flushAddress, branch, branchAddress,
               jumpReg, jumpAddress, call, ret,
        input  nextPC, rasEmpty, rasFull
    );

    modport slave (
        input  stall, flush, flushAddress, branch, branchAddress,
               jumpReg, jumpAddress, call, ret,
        output nextPC, rasEmpty, rasFull
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Registered program-counter sequencer with an optional circular
// return-address stack (RAS).
// Priority per rising edge: reset, flush, stall, taken branch, jumpReg,
// sequential increment. All address arithmetic wraps modulo 2^PC_WIDTH.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    pc_sequencer_if.slave (control inputs, nextPC, rasEmpty, rasFull)
// Configuration:
//   PC_SEQUENCER_RAS_EN  when defined, builds the return-address stack;
//                        otherwise call/ret are ignored, every jumpReg goes
//                        to jumpAddress, rasEmpty=1 and rasFull=0.
module pc_sequencer #(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  INSTR_BYTES  = 4,
    parameter int                  RAS_DEPTH    = 4
) (
    input logic            clk,
    input logic            rst_n,
    pc_sequencer_if.slave  bus
);

    logic [PC_WIDTH-1:0] pcReg;
    logic [PC_WIDTH-1:0] pcNext;
    logic [PC_WIDTH-1:0] seqPC;
    logic                branchTaken;
    logic                jumpSelected;
    logic                rasHit;
    logic [PC_WIDTH-1:0] rasTarget;

    assign seqPC        = pcReg + PC_WIDTH'(INSTR_BYTES);
    // Only the two one-hot encodings mean "taken"
    assign branchTaken  = bus.branch[0] ^ bus.branch[1];
    // The stack may only move when the jump path actually wins priority
    assign jumpSelected = bus.jumpReg && !bus.flush && !bus.stall && !branchTaken;

    always_comb begin
        pcNext = seqPC;
        if (bus.flush)
            pcNext = bus.flushAddress;
        else if (bus.stall)
            pcNext = pcReg;
        else if (branchTaken)
            pcNext = bus.branchAddress;
        else if (bus.jumpReg)
            pcNext = rasHit ? rasTarget : bus.jumpAddress;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pcReg <= RESET_VECTOR;
        else
            pcReg <= pcNext;
    end

    assign bus.nextPC = pcReg;

`ifdef PC_SEQUENCER_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_WIDTH-1:0] rasMem [RAS_DEPTH];
    logic [PTR_W-1:0]    topPtr;
    logic [PTR_W-1:0]    topNext;
    logic [PTR_W-1:0]    writePtr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    countNext;
    logic                rasWrite;
    logic                isEmpty;
    logic                isFull;
    logic                emptyReg;
    logic                fullReg;

    assign isEmpty = (count == '0);
    assign isFull  = (count == CNT_W'(RAS_DEPTH));

    // Stack update. A push advances the top pointer before writing, so when
    // the stack is full the slot it lands on is the oldest entry and gets
    // overwritten naturally. A swap on an empty stack behaves as a push.
    always_comb begin
        topNext   = topPtr;
        countNext = count;
        writePtr  = topPtr;
        rasWrite  = 1'b0;
        rasHit    = 1'b0;
        rasTarget = rasMem[topPtr];
        if (jumpSelected) begin
            if (bus.call && (!bus.ret || isEmpty)) begin
                rasWrite = 1'b1;
                writePtr = topPtr + PTR_W'(1);
                topNext  = topPtr + PTR_W'(1);
                if (!isFull)
                    countNext = count + CNT_W'(1);
            end else if (bus.ret && !bus.call) begin
                if (!isEmpty) begin
                    rasHit    = 1'b1;
                    topNext   = topPtr - PTR_W'(1);
                    countNext = count - CNT_W'(1);
                end
            end else if (bus.call && bus.ret) begin
                rasHit   = 1'b1;
                rasWrite = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            topPtr   <= '0;
            count    <= '0;
            emptyReg <= 1'b1;
            fullReg  <= 1'b0;
        end else begin
            topPtr   <= topNext;
            count    <= countNext;
            emptyReg <= (countNext == '0);
            fullReg  <= (countNext == CNT_W'(RAS_DEPTH));
        end
    end

    // Storage is not cleared by reset; the count alone decides validity
    always_ff @(posedge clk) begin
        if (rst_n && rasWrite)
            rasMem[writePtr] <= seqPC;
    end

    assign bus.rasEmpty = emptyReg;
    assign bus.rasFull  = fullReg;
`else
    assign rasHit       = 1'b0;
    assign rasTarget    = '0;
    assign bus.rasEmpty = 1'b1;
    assign bus.rasFull  = 1'b0;
`endif

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL expose the following parameters:
- PC_WIDTH, default 32, width of every address.
- RESET_VECTOR, default 0, PC value loaded at reset.
- INSTR_BYTES, default 4, sequential increment.
- RAS_DEPTH, default 4, return-address-stack entries (power of two, at least 2).

REQ-002 The block SHALL use one clock; reset is synchronous and active-low.

REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  hold PC and stack.
- flush  in  1  redirect to flushAddress (exception/mispredict).
- flushAddress  in  PC_WIDTH  flush target.
- branch  in  2  taken when 2'b01 or 2'b10; 2'b00 and 2'b11 mean not taken.
- branchAddress  in  PC_WIDTH  branch target.
- jumpReg  in  1  jump request.
- jumpAddress  in  PC_WIDTH  jump target.
- call  in  1  qualifies jumpReg as a call (push).
- ret  in  1  qualifies jumpReg as a return (pop).
- nextPC  out  PC_WIDTH  registered program counter.
- rasEmpty  out  1  stack holds 0 entries.
- rasFull  out  1  stack holds RAS_DEPTH entries.

Function
REQ-004 nextPC SHALL update only on the rising edge of clk; there is no combinational path from any input to nextPC.
REQ-005 Per edge, the first matching case in this priority list SHALL apply:
- !rst_n: reset.
- flush: nextPC<=flushAddress.
- stall: hold.
- branch taken: branchAddress.
- jumpReg: jump, call, or return.
- otherwise: nextPC+INSTR_BYTES.
REQ-006 Address arithmetic SHALL be modulo 2^PC_WIDTH; the all-ones address wraps to INSTR_BYTES-1 without error.
REQ-007 The return-address stack (RAS) SHALL be circular storage with a top pointer and an occupancy count of 0..RAS_DEPTH.
REQ-008 A call (jumpReg&call&!ret) SHALL:
- set nextPC<=jumpAddress;
- push nextPC+INSTR_BYTES;
- overwrite the oldest entry when full, with the count staying at RAS_DEPTH.
REQ-009 A return (jumpReg&ret&!call) SHALL:
- when not empty, set nextPC<=top entry and decrement the count;
- when empty, set nextPC<=jumpAddress and leave the stack unchanged.
REQ-010 When jumpReg&call&ret all hold (co-routine swap), the block SHALL set nextPC<=top entry (or jumpAddress if empty) and replace the top with nextPC+INSTR_BYTES; the count is unchanged unless it was 0, in which case it becomes 1.
REQ-011 call or ret asserted without jumpReg SHALL be ignored.
REQ-012 flush, stall, and branch taken SHALL leave the RAS unchanged, including when call or ret is also asserted.
REQ-013 rasEmpty and rasFull SHALL be registered and reflect the occupancy after the same edge that updates nextPC.

Reset
REQ-014 On a clk edge with rst_n=0, the block SHALL set nextPC<=RESET_VECTOR, set the count to 0 and the pointer to 0, and ignore all other inputs; stack storage contents need not be cleared.
REQ-015 Outputs after reset SHALL be: nextPC=RESET_VECTOR, rasEmpty=1, rasFull=0.
REQ-016 Reset asserted mid-sequence (stall active or stack full) SHALL take effect on that edge, with no residual state.

Configuration
REQ-017 With macro PC_SEQUENCER_RAS_EN defined, the block SHALL include the RAS as specified above.
REQ-018 Without PC_SEQUENCER_RAS_EN, the block SHALL:
- include no stack storage;
- ignore call and ret, so any jumpReg goes to jumpAddress;
- tie rasEmpty to 1 and rasFull to 0.

Verification
REQ-019 The bench SHALL cover the following directed scenarios (PC_WIDTH=32, RESET_VECTOR=0, INSTR_BYTES=4, RAS_DEPTH=4, RAS enabled):
- Reset, then 3 idle cycles -> nextPC 0x0, 0x4, 0x8, 0xC; rasEmpty=1.
- At nextPC=0x10: flush=1, flushAddress=0x80, branch=2'b01, stall=1 -> 0x80 (flush wins); next cycle stall=1 only -> 0x80 held.
- At 0x20: jumpReg+call, jumpAddress=0x100 -> 0x100 with stack top 0x24; then jumpReg+ret with jumpAddress=0x999 -> 0x24; rasEmpty=1.
- 5 nested calls from 0x0, 0x40, 0x80, 0xC0, 0x100 (each to the next) -> rasFull=1 after the 4th; 4 returns yield 0x104, 0xC4, 0x84, 0x44; a 5th return with jumpAddress=0x500 -> 0x500 (stack empty).
- nextPC=0xFFFFFFFC idle -> 0x00000000.
- branch=2'b11 with branchAddress=0x200 at 0x30 -> 0x34; branch=2'b10 -> 0x200; rst_n=0 while rasFull=1 -> nextPC=0, rasEmpty=1.
